// File: rtl/risc16_io_pkg.sv
// Shared constants and types for the risc16 data-bus I/O responder.
package risc16_io_pkg;

    localparam logic [15:0] UART_DATA_A = 16'hFF00;
    localparam logic [15:0] UART_STAT_A = 16'hFF02;
    localparam logic [15:0] CYC_LO_A    = 16'hFF04;
    localparam logic [15:0] CYC_HI_A    = 16'hFF06;
    localparam logic [15:0] DBUS_ERR_A  = 16'hFF08;
    localparam logic [15:0] DBUS_EADR_A = 16'hFF0A;

    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_FULL  = 1;
    localparam int unsigned STAT_EMPTY = 2;
    localparam int unsigned STAT_OVF   = 3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;

endpackage

// File: rtl/risc16_dbus_io_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; flags a push that arrives while full.
module tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout_c,
    output logic       full_c,
    output logic       empty_c,
    output logic       ovf_set_c
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full_c    = (count == CW'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_push   = push && !full_c;
    assign do_pop    = pop && !empty_c;
    // A pop in the same cycle never frees room for a push made while full.
    assign ovf_set_c = push && full_c;
    assign dout_c    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/risc16_dbus_io.sv
// Zero-wait data-side RAM, UART TX and cycle counter behind the risc16 data port.
// Optional bus-error capture register enabled by RISC16_DBUS_ERR_EN.
module risc16_dbus_io
    import risc16_io_pkg::*;
#(
    parameter int unsigned RAM_AW     = 14,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BAUD_DIV   = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    input  logic        doe,
    input  logic        dwe0,
    input  logic        dwe1,
    output logic [15:0] ddin,
    output logic        uart_tx
`ifdef RISC16_DBUS_ERR_EN
    ,
    output logic        bus_err
`endif
);
    localparam int unsigned RAM_WORDS = 1 << RAM_AW;
    localparam int unsigned BW        = $clog2(BAUD_DIV);

    logic              ram_sel, data_sel, stat_sel, lo_sel, hi_sel;
    logic [RAM_AW-1:0] widx;
    logic [15:0]       ram [RAM_WORDS];
    logic [31:0]       cyc;
    logic [15:0]       cyc_hi_snap;
    logic              ovf;
    logic [15:0]       stat_word;

    logic              fifo_full, fifo_empty, fifo_ovf_set, pop_c;
    logic [7:0]        fifo_dout;

    uart_st_t          st;
    logic [BW-1:0]     baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              baud_end;

    assign ram_sel  = ~daddr[15];
    assign data_sel = (daddr == UART_DATA_A);
    assign stat_sel = (daddr == UART_STAT_A);
    assign lo_sel   = (daddr == CYC_LO_A);
    assign hi_sel   = (daddr == CYC_HI_A);
    assign widx     = daddr[RAM_AW:1];

    // Big-endian byte lanes: dwe0 is the even (high) byte.
    always_ff @(posedge clk) begin
        if (ram_sel && dwe0) ram[widx][15:8] <= ddout[15:8];
        if (ram_sel && dwe1) ram[widx][7:0]  <= ddout[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc         <= '0;
            cyc_hi_snap <= '0;
        end else begin
            cyc <= cyc + 32'd1;
            if (lo_sel && doe) cyc_hi_snap <= cyc[31:16];
        end
    end

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (data_sel && dwe1),
        .din       (ddout[7:0]),
        .pop       (pop_c),
        .dout_c    (fifo_dout),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty),
        .ovf_set_c (fifo_ovf_set)
    );

    // Sticky overflow; a simultaneous set beats the software clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     ovf <= 1'b0;
        else if (fifo_ovf_set)                        ovf <= 1'b1;
        else if (stat_sel && dwe1 && ddout[STAT_OVF]) ovf <= 1'b0;
    end

    assign baud_end = (baud == BW'(BAUD_DIV - 1));
    assign pop_c    = !fifo_empty && ((st == IDLE) || (st == STOP && baud_end));

    // 8N1 transmitter; STOP chains straight into the next START when data waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (st)
                IDLE: begin
                    baud <= '0;
                    if (pop_c) begin
                        shift   <= fifo_dout;
                        st      <= START;
                        uart_tx <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        st      <= DATA;
                        uart_tx <= shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud    <= '0;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            st      <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (pop_c) begin
                            shift   <= fifo_dout;
                            st      <= START;
                            uart_tx <= 1'b0;
                        end else begin
                            st <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    st      <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        stat_word             = '0;
        stat_word[STAT_BUSY]  = (st != IDLE);
        stat_word[STAT_FULL]  = fifo_full;
        stat_word[STAT_EMPTY] = fifo_empty;
        stat_word[STAT_OVF]   = ovf;
    end

`ifdef RISC16_DBUS_ERR_EN
    logic        err_sel, eadr_sel, mapped;
    logic [15:0] err_addr;

    assign err_sel  = (daddr == DBUS_ERR_A);
    assign eadr_sel = (daddr == DBUS_EADR_A);
    assign mapped   = ram_sel | data_sel | stat_sel | lo_sel | hi_sel | err_sel | eadr_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else if ((doe || dwe0 || dwe1) && !mapped) begin
            bus_err  <= 1'b1;
            err_addr <= daddr;
        end else if (err_sel && dwe1) begin
            bus_err <= 1'b0;
        end
    end
`endif

    // Zero-wait read mux; RAM reads see pre-write data during a store.
    always_comb begin
        ddin = '0;
        if (ram_sel)       ddin = ram[widx];
        else if (stat_sel) ddin = stat_word;
        else if (lo_sel)   ddin = cyc[15:0];
        else if (hi_sel)   ddin = cyc_hi_snap;
`ifdef RISC16_DBUS_ERR_EN
        else if (err_sel)  ddin = {15'b0, bus_err};
        else if (eadr_sel) ddin = err_addr;
`endif
    end

endmodule
